// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the multi-port register file.
//   DW_DEF / AW_DEF : default data and address widths
//   REG_ZERO        : index of the hardwired-zero register
//   slice_lo()      : bit offset of element idx in a flat bus of w-bit elements
package regfile_pkg;

    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;
    localparam int REG_ZERO = 0;

    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: ID/WB-side bus of the multi-port register file.
//   ra/rd/rbusy          : NR read ports (address, data, busy of addressed reg)
//   we/wn/d              : NW write ports (enable, address, data)
//   set_en/set_rn        : issue-time busy mark
//   busy_cnt/wr_conflict : registered status
// master = pipeline side, slave = register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int NR = 2,
    parameter int NW = 2
);

    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rbusy;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] wn;
    logic [NW*DW-1:0] d;
    logic             set_en;
    logic [AW-1:0]    set_rn;
    logic [AW:0]      busy_cnt;
    logic             wr_conflict;

    modport master (
        output ra, we, wn, d, set_en, set_rn,
        input  rd, rbusy, busy_cnt, wr_conflict
    );

    modport slave (
        input  ra, we, wn, d, set_en, set_rn,
        output rd, rbusy, busy_cnt, wr_conflict
    );

endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: per-register busy scoreboard.
//   clk, clrn : clock, async active-low reset
//   weff      : effective write strobes (zero-register writes already removed)
//   wn        : write addresses, flat NW*AW
//   set_en/set_rn : mark a register busy at issue
//   ra        : read addresses, flat NR*AW
//   rbusy     : busy bit seen by each read port
//   busy_cnt  : registered count of busy registers
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int NR       = 2,
    parameter int NW       = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [NW-1:0]    weff,
    input  logic [NW*AW-1:0] wn,
    input  logic             set_en,
    input  logic [AW-1:0]    set_rn,
    input  logic [NR*AW-1:0] ra,
    output logic [NR-1:0]    rbusy,
    output logic [AW:0]      busy_cnt
);

    localparam int DEPTH = 2**AW;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;
    logic             set_eff;

    assign set_eff = set_en && !(ZERO_REG && set_rn == AW'(REG_ZERO));

    // Clears first, set last: a new producer issued in the same cycle as the
    // old one retires keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NW; j++) begin
            if (weff[j]) busy_nxt[wn[slice_lo(j, AW) +: AW]] = 1'b0;
        end
        if (set_eff) busy_nxt[set_rn] = 1'b1;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[k]);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // A retiring write in the same cycle hides the busy bit when bypassing,
    // since the reader also gets the bypassed data. Same-cycle sets are not
    // visible until the register updates.
    always_comb begin
        logic [AW-1:0] a;
        logic          hit;
        rbusy = '0;
        a     = '0;
        hit   = 1'b0;
        for (int i = 0; i < NR; i++) begin
            a   = ra[slice_lo(i, AW) +: AW];
            hit = 1'b0;
            for (int j = 0; j < NW; j++) begin
                if (weff[j] && wn[slice_lo(j, AW) +: AW] == a) hit = 1'b1;
            end
            rbusy[i] = busy[a] && !(BYPASS && hit)
                       && !(ZERO_REG && a == AW'(REG_ZERO));
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with bypass, busy
// scoreboard and write-conflict flag.
//   clk  : clock, rising edge
//   clrn : async active-low reset
//   bus  : regfile_mp_if.slave (read ports, write ports, busy set, status)
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int NR       = 2,
    parameter int NW       = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic        clk,
    input  logic        clrn,
    regfile_mp_if.slave bus
);

    localparam int DEPTH = 2**AW;

    // Flat packed storage: register k lives at bits [k*DW +: DW].
    logic [DEPTH*DW-1:0] mem;
    logic [NW-1:0]       weff;
    logic                conflict;
    logic                wr_conflict_q;
    logic [NR*DW-1:0]    rd_v;

    always_comb begin
        weff = '0;
        for (int j = 0; j < NW; j++) begin
            weff[j] = bus.we[j]
                      && !(ZERO_REG && bus.wn[slice_lo(j, AW) +: AW] == AW'(REG_ZERO));
        end
    end

    always_comb begin
        conflict = 1'b0;
        for (int j = 0; j < NW; j++) begin
            for (int k = j + 1; k < NW; k++) begin
                if (weff[j] && weff[k]
                    && bus.wn[slice_lo(j, AW) +: AW] == bus.wn[slice_lo(k, AW) +: AW])
                    conflict = 1'b1;
            end
        end
    end

    // Ascending port order: the last non-blocking assignment wins, so the
    // highest-index write port takes priority on a collision.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mem <= '0;
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (weff[j])
                    mem[slice_lo(int'(bus.wn[slice_lo(j, AW) +: AW]), DW) +: DW]
                        <= bus.d[slice_lo(j, DW) +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) wr_conflict_q <= 1'b0;
        else       wr_conflict_q <= conflict;
    end

    assign bus.wr_conflict = wr_conflict_q;

    always_comb begin
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        rd_v = '0;
        a    = '0;
        v    = '0;
        for (int i = 0; i < NR; i++) begin
            a = bus.ra[slice_lo(i, AW) +: AW];
            v = mem[slice_lo(int'(a), DW) +: DW];
            if (BYPASS) begin
                for (int j = 0; j < NW; j++) begin
                    if (weff[j] && bus.wn[slice_lo(j, AW) +: AW] == a)
                        v = bus.d[slice_lo(j, DW) +: DW];
                end
            end
            if (ZERO_REG && a == AW'(REG_ZERO)) v = '0;
            rd_v[slice_lo(i, DW) +: DW] = v;
        end
    end

    assign bus.rd = rd_v;

    regfile_sb #(
        .AW       (AW),
        .NR       (NR),
        .NW       (NW),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk      (clk),
        .clrn     (clrn),
        .weff     (weff),
        .wn       (bus.wn),
        .set_en   (bus.set_en),
        .set_rn   (bus.set_rn),
        .ra       (bus.ra),
        .rbusy    (bus.rbusy),
        .busy_cnt (bus.busy_cnt)
    );

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Multi-port, parametrised register file for the pipelined CPU; next generation of the 2-read/1-write integer register file.
- Adds configurable read/write port counts, data width and depth.
- Adds same-cycle write-to-read bypass, a per-register busy scoreboard for hazard detection, and a write-conflict flag.
- Sits in ID (reads, busy check, issue-time set) and WB (writes, busy clear).

Parameters:
- DW, 32, data width in bits
- AW, 5, address width; depth = 2**AW registers
- NR, 2, number of read ports (1..4)
- NW, 2, number of write ports (1..2)
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy
- BYPASS, 1, 1 = same-cycle write data and busy clears are visible on reads

Ports:
- clk  in  1  clock, rising edge
- clrn  in  1  reset, asynchronous, active low
- ra  in  NR*AW  read addresses; port i = ra[i*AW +: AW]
- rd  out  NR*DW  read data; port i = rd[i*DW +: DW]
- rbusy  out  NR  busy bit of register addressed by port i
- we  in  NW  write enable per write port
- wn  in  NW*AW  write addresses
- d  in  NW*DW  write data
- set_en  in  1  mark register set_rn busy (instruction issued with a destination)
- set_rn  in  AW  register to mark busy
- busy_cnt  out  AW+1  number of currently busy registers (registered)
- wr_conflict  out  1  registered one-cycle pulse: two write ports hit the same register in the previous cycle

Behaviour:
- Reset (clrn=0, asynchronous): all registers = 0, all busy bits = 0, busy_cnt = 0, wr_conflict = 0. Combinational rd/rbusy follow the cleared state immediately.
- Effective write j: we[j]=1 and not (ZERO_REG and wn_j==0).
- Storage: on posedge clk, each effective write updates reg[wn_j] <= d_j.
  - Two effective writes to the same register: higher port index wins.
  - That case also sets wr_conflict=1 for the next cycle; otherwise wr_conflict=0.
- Reads, combinational, evaluated per port i in this priority:
  - (a) ZERO_REG and ra_i==0 -> rd_i = 0.
  - (b) BYPASS and some effective write j has wn_j==ra_i -> rd_i = d_j, using the highest such j.
  - (c) Otherwise rd_i = reg[ra_i].
- With BYPASS=0, a written value is visible on the cycle after the write edge.
- Scoreboard, one busy bit per register, updated on posedge clk:
  - Clear busy[wn_j] for every effective write j.
  - Set busy[set_rn] if set_en and not (ZERO_REG and set_rn==0).
  - Set and clear of the same register in the same cycle: set wins (new producer issued).
  - Setting an already-busy register leaves it busy; busy_cnt does not double-count.
  - Clearing a non-busy register has no effect.
- rbusy_i:
  - 0 if ZERO_REG and ra_i==0.
  - Else busy[ra_i] AND NOT (BYPASS and an effective write to ra_i is present this cycle).
  - A same-cycle set_en is NOT reflected until the next cycle.
- busy_cnt: registered population count of busy bits after the edge's updates; range 0..2**AW (0..2**AW-1 when ZERO_REG=1). Never wraps.
- Reset mid-operation: every in-flight write and set on that cycle is discarded.
- Width rules: all addresses are unsigned; there is no out-of-range address because depth = 2**AW.

Decomposition:
- Shared package regfile_pkg: default DW/AW constants, REG_ZERO constant, port-slice helper functions (index-to-bit-offset).
- One sub-module, regfile_sb: busy bit vector, set/clear priority logic, busy_cnt, and per-read-port rbusy masking.
- Top level holds the storage array, write-port priority, bypass mux and wr_conflict.

Test Plan:
- Reset: write reg 5=0xDEADBEEF, pulse clrn low mid-cycle (asynchronous) -> rd for ra=5 is 0 immediately; busy_cnt=0; wr_conflict=0.
- Bypass: same cycle we[0]=1, wn0=7, d0=0x12345678, ra0=7 -> rd0=0x12345678 before the edge with BYPASS=1. With BYPASS=0 -> old value before the edge, 0x12345678 after it.
- Zero register: write 0xFFFFFFFF to reg 0 and set_en with set_rn=0 -> rd=0, rbusy=0, busy_cnt unchanged.
- Write conflict: we=2'b11, wn0=wn1=9, d0=0xA, d1=0xB -> reg 9=0xB; wr_conflict=1 for exactly one cycle, then 0.
- Scoreboard: set_rn=3 (cycle 1) -> rbusy for ra=3 =1 and busy_cnt=1 from cycle 2. Write reg 3 with set_en/set_rn=3 in the same cycle -> stays busy, busy_cnt=1. Plain write to reg 3 on the next cycle -> rbusy=0 that cycle (BYPASS=1), busy_cnt=0 after the edge.
- Saturation: set every register 1..31 over 31 cycles, then re-set reg 4 -> busy_cnt=31 and does not increment.
